// File: rtl/ftdi_cmd_ctrl.sv
// ftdi_cmd_ctrl: parses host command bytes from the FTDI RX stream into
// register-bus reads/writes and streams the response bytes back on TX.
// Build option: define FTDI_CMD_CSUM_EN to add a trailing XOR checksum byte
// to every command and every response (including error codes).
module ftdi_cmd_ctrl #(
  parameter int RX_TIMEOUT  = 1000000,
  parameter int BUS_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy
);
  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] ERR_OP = 8'h45;
  localparam logic [7:0] ERR_TO = 8'h54;
  localparam int RXW = $clog2(RX_TIMEOUT + 1);
  localparam int BW  = $clog2(BUS_TIMEOUT + 1);

`ifdef FTDI_CMD_CSUM_EN
  localparam logic [7:0] ERR_CS = 8'h43;
  // Index of the final TX byte: payload plus one checksum byte.
  localparam logic [2:0] LAST_ONE = 3'd1;
  localparam logic [2:0] LAST_RD  = 3'd4;
`else
  localparam logic [2:0] LAST_ONE = 3'd0;
  localparam logic [2:0] LAST_RD  = 3'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
`ifdef FTDI_CMD_CSUM_EN
    S_CSUM,
`endif
    S_BUS,
    S_RESP,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        rx_acc_d;
  logic        is_wr_q;
  logic [1:0]  wcnt_q;
  logic [RXW-1:0] rx_cnt_q;
  logic [BW-1:0]  bus_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [31:0] rdata_q;
  logic [7:0]  err_q, err_d;
`ifdef FTDI_CMD_CSUM_EN
  logic [7:0]  csum_q;
`endif

  logic rx_fire, tx_fire, rx_to, bus_to, tx_last, in_pkt;

  assign rx_fire = rx_tvalid & rx_tready;
  assign tx_fire = tx_tvalid & tx_tready;
  assign rx_to   = (rx_cnt_q == RXW'(RX_TIMEOUT - 1));
  assign bus_to  = (bus_cnt_q == BW'(BUS_TIMEOUT - 1));
  // Read responses are 4 data bytes; write ack and error codes are one byte.
  assign tx_last = (state_q == S_RESP && !is_wr_q) ? (tx_idx_q == LAST_RD)
                                                   : (tx_idx_q == LAST_ONE);
`ifdef FTDI_CMD_CSUM_EN
  assign in_pkt = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_CSUM);
  assign rx_acc_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                    (state_d == S_WDATA) || (state_d == S_CSUM);
`else
  assign in_pkt = (state_q == S_ADDR) || (state_q == S_WDATA);
  assign rx_acc_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
`endif

  // State register; rx_tready is registered from the next state so it is low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_tready <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      rx_tready <= rx_acc_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; an accepted byte always takes priority over the RX timeout.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_tdata == OP_WR || rx_tdata == OP_RD) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_OP;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
`ifdef FTDI_CMD_CSUM_EN
          state_d = is_wr_q ? S_WDATA : S_CSUM;
`else
          state_d = is_wr_q ? S_WDATA : S_BUS;
`endif
        end else if (rx_to) begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          if (wcnt_q == 2'd3) begin
`ifdef FTDI_CMD_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_BUS;
`endif
          end
        end else if (rx_to) begin
          state_d = S_IDLE;
        end
      end
`ifdef FTDI_CMD_CSUM_EN
      S_CSUM: begin
        if (rx_fire) begin
          if (rx_tdata == csum_q) begin
            state_d = S_BUS;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_CS;
          end
        end else if (rx_to) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_BUS: begin
        if (reg_ack) begin
          state_d = S_RESP;
        end else if (bus_to) begin
          state_d = S_ERR;
          err_d   = ERR_TO;
        end
      end
      S_RESP, S_ERR: begin
        if (tx_fire && tx_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; strobes follow the BUS state exactly.
  always_comb begin
    busy      = (state_q != S_IDLE);
    reg_we    = (state_q == S_BUS) &  is_wr_q;
    reg_re    = (state_q == S_BUS) & ~is_wr_q;
    tx_tvalid = 1'b0;
    tx_tdata  = 8'h00;
    case (state_q)
      S_RESP: begin
        tx_tvalid = 1'b1;
        // XOR over the single byte 0x4B is 0x4B, so the write ack repeats it.
        if (is_wr_q) tx_tdata = RSP_OK;
`ifdef FTDI_CMD_CSUM_EN
        else if (tx_idx_q[2]) tx_tdata = rdata_q[7:0] ^ rdata_q[15:8] ^
                                         rdata_q[23:16] ^ rdata_q[31:24];
`endif
        else tx_tdata = rdata_q[{tx_idx_q[1:0], 3'b000} +: 8];
      end
      S_ERR: begin
        // Error code and its checksum byte are the same value.
        tx_tvalid = 1'b1;
        tx_tdata  = err_q;
      end
      default: ;
    endcase
  end

  // Datapath: byte capture, saturating counters and read-data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr_q   <= 1'b0;
      wcnt_q    <= 2'd0;
      rx_cnt_q  <= '0;
      bus_cnt_q <= '0;
      tx_idx_q  <= 3'd0;
      rdata_q   <= 32'h0;
      reg_addr  <= 8'h00;
      reg_wdata <= 32'h0;
`ifdef FTDI_CMD_CSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      if (rx_fire || !in_pkt) rx_cnt_q <= '0;
      else if (!rx_to)        rx_cnt_q <= rx_cnt_q + RXW'(1);

      if (state_q != S_BUS) bus_cnt_q <= '0;
      else if (!bus_to)     bus_cnt_q <= bus_cnt_q + BW'(1);

      if (state_q != S_RESP && state_q != S_ERR) tx_idx_q <= 3'd0;
      else if (tx_fire)                          tx_idx_q <= tx_idx_q + 3'd1;

      if (rx_fire) begin
        case (state_q)
          S_IDLE: begin
            is_wr_q <= (rx_tdata == OP_WR);
            wcnt_q  <= 2'd0;
`ifdef FTDI_CMD_CSUM_EN
            csum_q  <= rx_tdata;
`endif
          end
          S_ADDR: begin
            reg_addr <= rx_tdata;
`ifdef FTDI_CMD_CSUM_EN
            csum_q   <= csum_q ^ rx_tdata;
`endif
          end
          S_WDATA: begin
            reg_wdata[{wcnt_q, 3'b000} +: 8] <= rx_tdata;
            wcnt_q <= wcnt_q + 2'd1;
`ifdef FTDI_CMD_CSUM_EN
            csum_q <= csum_q ^ rx_tdata;
`endif
          end
          default: ;
        endcase
      end

      if (state_q == S_BUS && reg_ack) rdata_q <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_ftdi_cmd_ctrl.sv
// tb_ftdi_cmd_ctrl: table-driven command vectors plus hand-written reset,
// back-to-back and inter-byte-gap sequences for ftdi_cmd_ctrl.
module tb_ftdi_cmd_ctrl;
  localparam int RXT = 16;
  localparam int BT  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_tdata = 8'h00;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we, reg_re;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_ack = 1'b0;
  logic        busy;

  ftdi_cmd_ctrl #(.RX_TIMEOUT(RXT), .BUS_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rx;     // command bytes, first byte in [63:56]
    int          nrx;
    bit          raw;    // no checksum byte appended in the checksum build
    int          dly;    // ack on strobe cycle dly (0 = first), -1 = never
    logic [31:0] rdata;
    int          stall;  // tx_tready low cycles per response byte
    logic [63:0] tx;     // expected response payload, first byte in [63:56]
    int          ntx;
    int          we;     // expected reg_we high cycles
    int          re;     // expected reg_re high cycles
    logic [7:0]  addr;   // expected reg_addr afterwards
    logic [31:0] wdata;  // expected reg_wdata afterwards
  } vec_t;

  vec_t vecs[$];
  int checks = 0, fails = 0;
  int ack_dly = 0, stall_n = 0;
  int we_cyc = 0, re_cyc = 0, strobe_cyc = 0, bad_rdy = 0, unstable = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] xr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [63:0] rx, input int nrx, input bit raw, input int dly,
                      input logic [31:0] rdata, input int stall, input logic [63:0] tx,
                      input int ntx, input int we, input int re, input logic [7:0] addr,
                      input logic [31:0] wdata);
    vec_t v;
    v.rx = rx; v.nrx = nrx; v.raw = raw; v.dly = dly; v.rdata = rdata; v.stall = stall;
    v.tx = tx; v.ntx = ntx; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    vecs.push_back(v);
  endtask

  // Append one command packet (plus its checksum in the checksum build).
  task automatic add_rx(input logic [63:0] b, input int n, input bit raw);
    xr = 8'h00;
    for (int i = 0; i < n; i++) begin
      rxq.push_back(b[8*(7-i) +: 8]);
      xr ^= b[8*(7-i) +: 8];
    end
`ifdef FTDI_CMD_CSUM_EN
    if (!raw) rxq.push_back(xr);
`endif
  endtask

  // Append one expected response (plus its checksum in the checksum build).
  task automatic add_exp(input logic [63:0] b, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      expq.push_back(b[8*(7-i) +: 8]);
      x ^= b[8*(7-i) +: 8];
    end
`ifdef FTDI_CMD_CSUM_EN
    if (n > 0) expq.push_back(x);
`endif
  endtask

  // Register-bus responder: counts strobe cycles, raises ack on the chosen cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reg_ack = 1'b0; strobe_cyc = 0;
      end else if (reg_we || reg_re) begin
        if (reg_we) we_cyc++;
        if (reg_re) re_cyc++;
        if (rx_tready) bad_rdy++;
        reg_ack = (ack_dly >= 0) && (strobe_cyc == ack_dly);
        strobe_cyc++;
      end else begin
        reg_ack = 1'b0; strobe_cyc = 0;
      end
    end
  end

  // TX sink: stalls each byte stall_n cycles, checks stability, records bytes.
  initial begin
    int vcnt;
    bit held;
    logic [7:0] hold_d;
    vcnt = 0; held = 0; hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0; vcnt = 0; tx_tready = 1'b0;
      end else if (tx_tvalid) begin
        if (held && tx_tdata != hold_d) unstable++;
        if (rx_tready) bad_rdy++;
        held = 1; hold_d = tx_tdata;
        tx_tready = (vcnt >= stall_n);
        if (tx_tready) begin
          txq.push_back(tx_tdata); held = 0; vcnt = 0;
        end else vcnt++;
      end else begin
        tx_tready = 1'b0; held = 0;
      end
    end
  end

  // Drive rxq byte by byte; called and returns on a negedge.
  task automatic send_rx();
    int c;
    foreach (rxq[i]) begin
      rx_tdata = rxq[i]; rx_tvalid = 1'b1;
      c = 0;
      while (!rx_tready && c < 300) begin @(negedge clk); c++; end
      if (!rx_tready) begin
        checks++; fails++;
        $display("FAIL rx_handshake: byte %0d not accepted within 300 cycles", i);
        rx_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 600) begin @(negedge clk); c++; end
    if (busy) begin
      checks++; fails++;
      $display("FAIL %s idle_wait: busy still %0d after 600 cycles", nm, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_tx(input string nm, input int tb0);
    chk({nm, " tx_count"}, 64'(txq.size() - tb0), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (tb0 + i < txq.size()) chk($sformatf("%s tx_byte%0d", nm, i), 64'(txq[tb0+i]), 64'(expq[i]));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int we0, re0, tb0;
    ack_dly = v.dly; reg_rdata = v.rdata; stall_n = v.stall;
    we0 = we_cyc; re0 = re_cyc; tb0 = txq.size();
    rxq.delete(); expq.delete();
    add_rx(v.rx, v.nrx, v.raw);
    add_exp(v.tx, v.ntx);
    send_rx();
    wait_idle(nm);
    check_tx(nm, tb0);
    chk({nm, " we_cycles"}, 64'(we_cyc - we0), 64'(v.we));
    chk({nm, " re_cycles"}, 64'(re_cyc - re0), 64'(v.re));
    chk({nm, " reg_addr"}, 64'(reg_addr), 64'(v.addr));
    chk({nm, " reg_wdata"}, 64'(reg_wdata), 64'(v.wdata));
  endtask

  initial begin
    int c, we0, re0, tb0;
    vec_t fv;
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, we0, re0, tb0;
    vec_t fv;
    // rx, n, raw, dly, rdata, stall, tx, ntx, we, re, addr, wdata
    addv(64'h5710EFBEADDE0000, 6, 0, 2,  32'h0,        0,  64'h4B00000000000000, 1, 3, 0,  8'h10, 32'hDEADBEEF);
    addv(64'h5220000000000000, 2, 0, 0,  32'h12345678, 0,  64'h7856341200000000, 4, 0, 1,  8'h20, 32'hDEADBEEF);
    addv(64'h5233000000000000, 2, 0, 1,  32'hA5A50F0F, 10, 64'h0F0FA5A500000000, 4, 0, 2,  8'h33, 32'hDEADBEEF);
    addv(64'h9900000000000000, 1, 1, 0,  32'h0,        0,  64'h4500000000000000, 1, 0, 0,  8'h33, 32'hDEADBEEF);
    addv(64'h5205000000000000, 2, 0, 0,  32'hCAFEBABE, 0,  64'hBEBAFECA00000000, 4, 0, 1,  8'h05, 32'hDEADBEEF);
    addv(64'h5244000000000000, 2, 0, -1, 32'h0,        0,  64'h5400000000000000, 1, 0, BT, 8'h44, 32'hDEADBEEF);
    addv(64'h5710110000000000, 3, 1, 0,  32'h0,        0,  64'h0,                0, 0, 0,  8'h10, 32'hDEADBE11);
    addv(64'h577F010203040000, 6, 0, 0,  32'h0,        0,  64'h4B00000000000000, 1, 1, 0,  8'h7F, 32'h04030201);
    addv(64'h5257000000000000, 2, 0, BT-1, 32'h00FF8001, 3, 64'h0180FF0000000000, 4, 0, BT, 8'h57, 32'h04030201);
    addv(64'h5757575757570000, 6, 0, 0,  32'h0,        0,  64'h4B00000000000000, 1, 1, 0,  8'h57, 32'h57575757);
`ifdef FTDI_CMD_CSUM_EN
    addv(64'h5220000000000000, 3, 1, 0,  32'h0,        0,  64'h4300000000000000, 1, 0, 0,  8'h20, 32'h57575757);
`endif

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({rx_tready, tx_tvalid, tx_tdata, reg_we, reg_re, reg_addr, reg_wdata, busy}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rx_tready", 64'(rx_tready), 64'h1);
    chk("post_reset_busy", 64'(busy), 64'h0);

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("v%0d", k));

    // Two reads back to back: the second waits in the RX FIFO during BUS/RESP
    ack_dly = 0; reg_rdata = 32'h12345678; stall_n = 2;
    re0 = re_cyc; tb0 = txq.size();
    rxq.delete(); expq.delete();
    add_rx(64'h5220000000000000, 2, 0);
    add_rx(64'h5221000000000000, 2, 0);
    add_exp(64'h7856341200000000, 4);
    add_exp(64'h7856341200000000, 4);
    send_rx();
    wait_idle("b2b");
    check_tx("b2b", tb0);
    chk("b2b re_cycles", 64'(re_cyc - re0), 64'd2);
    chk("b2b reg_addr", 64'(reg_addr), 64'h21);

    // Inter-byte gap just below the timeout keeps the packet alive
    ack_dly = 0; stall_n = 0;
    we0 = we_cyc; tb0 = txq.size();
    rxq.delete(); expq.delete();
    rxq.push_back(8'h57); rxq.push_back(8'h10);
    send_rx();
    repeat (RXT - 2) @(negedge clk);
    chk("gap busy_held", 64'(busy), 64'h1);
    rxq.delete();
    rxq.push_back(8'hEF); rxq.push_back(8'hBE); rxq.push_back(8'hAD); rxq.push_back(8'hDE);
`ifdef FTDI_CMD_CSUM_EN
    rxq.push_back(8'h57 ^ 8'h10 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
    send_rx();
    add_exp(64'h4B00000000000000, 1);
    wait_idle("gap");
    check_tx("gap", tb0);
    chk("gap we_cycles", 64'(we_cyc - we0), 64'd1);
    chk("gap reg_wdata", 64'(reg_wdata), 64'hDEADBEEF);

    // Async reset in the middle of a response
    ack_dly = 0; reg_rdata = 32'h11223344; stall_n = 40;
    rxq.delete(); add_rx(64'h5220000000000000, 2, 0);
    send_rx();
    c = 0;
    while (!tx_tvalid && c < 100) begin @(negedge clk); c++; end
    chk("rst_resp reached", 64'(tx_tvalid), 64'h1);
    rst_n = 1'b0; #1;
    chk("rst_resp outputs", 64'({tx_tvalid, tx_tdata, busy, rx_tready, reg_re, reg_addr, reg_wdata}), 64'h0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Async reset in the middle of a read strobe
    ack_dly = -1; stall_n = 0;
    rxq.delete(); add_rx(64'h5220000000000000, 2, 0);
    send_rx();
    c = 0;
    while (!reg_re && c < 100) begin @(negedge clk); c++; end
    chk("rst_bus reached", 64'(reg_re), 64'h1);
    rst_n = 1'b0; #1;
    chk("rst_bus outputs", 64'({reg_re, reg_we, busy, tx_tvalid}), 64'h0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Normal read after reset; write data register was cleared by reset
    fv.rx = 64'h5220000000000000; fv.nrx = 2; fv.raw = 0; fv.dly = 0; fv.rdata = 32'h12345678;
    fv.stall = 0; fv.tx = 64'h7856341200000000; fv.ntx = 4; fv.we = 0; fv.re = 1;
    fv.addr = 8'h20; fv.wdata = 32'h0;
    run_vec(fv, "post_rst");

    chk("tx_stable", 64'(unstable), 64'h0);
    chk("rx_tready_low_when_busy_bus_tx", 64'(bad_rdy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
